// File: rtl/enc_fetch_pkg.sv
//------------------------------------------------------------------------------
// Module : enc_fetch_pkg
// Brief  : Shared state encodings and defaults for the fetch SRAM controller.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package enc_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_LOAD  = 2'd1,
    FETCH_READY = 2'd2
  } fetch_state_e;

  localparam int FETCH_BLK_BEATS = 32;

endpackage

`default_nettype wire

// File: rtl/fetch_ram_1p_sub.sv
//------------------------------------------------------------------------------
// Module : fetch_ram_1p_sub
// Brief  : Wrapper around the 128x32 single-port fetch SRAM (active-low pins).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_ram_1p_sub #(
  parameter int Word_Width = 128,
  parameter int Addr_Width = 5
) (
  input  logic                  clk,
  input  logic                  cen,
  input  logic                  wen,
  input  logic                  oen,
  input  logic [Addr_Width-1:0] addr,
  input  logic [Word_Width-1:0] d,
  output logic [Word_Width-1:0] q
);

  logic [Word_Width-1:0] mem [2**Addr_Width];
  logic [Word_Width-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!wen) begin
        mem[addr] <= d;
      end else begin
        q_reg <= mem[addr];
      end
    end
  end

  assign q = oen ? '0 : q_reg;

endmodule

`default_nettype wire

// File: rtl/fetch_ram_1p_ctrl.sv
//------------------------------------------------------------------------------
// Module : fetch_ram_1p_ctrl
// Brief  : Loads a block of beats into the fetch SRAM, then serves reads.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_ram_1p_ctrl
  import enc_fetch_pkg::*;
#(
  parameter int Word_Width = 128,
  parameter int Addr_Width = 5,
  parameter int Blk_Beats  = FETCH_BLK_BEATS
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic                  in_val_i,
  input  logic [Word_Width-1:0] in_dat_i,
  output logic                  in_rdy_o,
  output logic                  done_o,
  output logic                  blk_vld_o,
  input  logic                  rd_req_i,
  input  logic [Addr_Width-1:0] rd_addr_i,
  output logic                  rd_val_o,
  output logic [Word_Width-1:0] rd_dat_o,
  output logic                  ram_cen_o,
  output logic                  ram_wen_o,
  output logic                  ram_oen_o,
  output logic [Addr_Width-1:0] ram_addr_o,
  output logic [Word_Width-1:0] ram_dat_o,
  input  logic [Word_Width-1:0] ram_dat_i
);

  localparam logic [Addr_Width:0] LAST_CNT = (Addr_Width+1)'(Blk_Beats - 1);

  fetch_state_e          state, state_nxt;
  logic [Addr_Width:0]   wr_cnt;
  logic                  in_rdy;
  logic                  blk_vld;
  logic                  rd_val;
  logic [Addr_Width-1:0] addr_hold;
  logic [Word_Width-1:0] dat_hold;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  last_beat;

  assign wr_fire   = (state == FETCH_LOAD) && in_val_i && in_rdy;
  assign rd_fire   = (state == FETCH_READY) && rd_req_i;
  assign last_beat = wr_fire && (wr_cnt == LAST_CNT);

  always_comb begin
    state_nxt  = state;
    ram_cen_o  = 1'b1;
    ram_wen_o  = 1'b1;
    ram_addr_o = addr_hold;
    ram_dat_o  = dat_hold;
    case (state)
      FETCH_IDLE: begin
        if (start_i) state_nxt = FETCH_LOAD;
      end
      FETCH_LOAD: begin
        if (wr_fire) begin
          ram_cen_o  = 1'b0;
          ram_wen_o  = 1'b0;
          ram_addr_o = wr_cnt[Addr_Width-1:0];
          ram_dat_o  = in_dat_i;
        end
        if (last_beat) state_nxt = FETCH_READY;
      end
      FETCH_READY: begin
        // A read coinciding with start_i is still issued; writes begin next cycle.
        if (rd_fire) begin
          ram_cen_o  = 1'b0;
          ram_addr_o = rd_addr_i;
        end
        if (start_i) state_nxt = FETCH_LOAD;
      end
      default: state_nxt = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= FETCH_IDLE;
      wr_cnt    <= '0;
      in_rdy    <= 1'b0;
      blk_vld   <= 1'b0;
      rd_val    <= 1'b0;
      addr_hold <= '0;
      dat_hold  <= '0;
    end else begin
      state     <= state_nxt;
      in_rdy    <= (state_nxt == FETCH_LOAD);
      blk_vld   <= (state_nxt == FETCH_READY);
      rd_val    <= rd_fire;
      addr_hold <= ram_addr_o;
      dat_hold  <= ram_dat_o;
      if (start_i && (state != FETCH_LOAD)) begin
        wr_cnt <= '0;
      end else if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  assign in_rdy_o  = in_rdy;
  assign done_o    = last_beat;
  assign blk_vld_o = blk_vld;
  assign rd_val_o  = rd_val;
  assign rd_dat_o  = rd_val ? ram_dat_i : '0;
  assign ram_oen_o = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ram_1p_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_fetch_ram_1p_ctrl
// Brief  : Self-checking bench for fetch_ram_1p_ctrl with the fetch SRAM model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_ram_1p_ctrl;

  localparam int WW = 128;
  localparam int AW = 5;
  localparam int BB = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start_i = 1'b0;
  logic          in_val_i = 1'b0;
  logic [WW-1:0] in_dat_i = '0;
  logic          in_rdy_o;
  logic          done_o;
  logic          blk_vld_o;
  logic          rd_req_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;
  logic          rd_val_o;
  logic [WW-1:0] rd_dat_o;
  logic          ram_cen_o;
  logic          ram_wen_o;
  logic          ram_oen_o;
  logic [AW-1:0] ram_addr_o;
  logic [WW-1:0] ram_dat_o;
  logic [WW-1:0] ram_dat_i;

  int errors = 0;
  int checks = 0;
  logic [WW-1:0] rd_q[$];
  int rd_addrs[$];

  always #5 clk = ~clk;

  fetch_ram_1p_ctrl #(
    .Word_Width(WW),
    .Addr_Width(AW),
    .Blk_Beats (BB)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start_i   (start_i),
    .in_val_i  (in_val_i),
    .in_dat_i  (in_dat_i),
    .in_rdy_o  (in_rdy_o),
    .done_o    (done_o),
    .blk_vld_o (blk_vld_o),
    .rd_req_i  (rd_req_i),
    .rd_addr_i (rd_addr_i),
    .rd_val_o  (rd_val_o),
    .rd_dat_o  (rd_dat_o),
    .ram_cen_o (ram_cen_o),
    .ram_wen_o (ram_wen_o),
    .ram_oen_o (ram_oen_o),
    .ram_addr_o(ram_addr_o),
    .ram_dat_o (ram_dat_o),
    .ram_dat_i (ram_dat_i)
  );

  fetch_ram_1p_sub #(
    .Word_Width(WW),
    .Addr_Width(AW)
  ) u_ram (
    .clk (clk),
    .cen (ram_cen_o),
    .wen (ram_wen_o),
    .oen (ram_oen_o),
    .addr(ram_addr_o),
    .d   (ram_dat_o),
    .q   (ram_dat_i)
  );

  function automatic logic [WW-1:0] pat(input int a, input bit alt);
    logic [7:0] b;
    b = 8'(a);
    pat = {16{b}};
    if (alt) pat = ~pat;
  endfunction

  // Each cycle: drive just after posedge, check at negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit from_ready);
    start_i = 1'b1;
    @(negedge clk);
    checks++;
    if (in_rdy_o !== 1'b0 || ram_wen_o !== 1'b1)
      $display("FAIL start_cycle: in_rdy=%b wen=%b, want in_rdy=0 wen=1", in_rdy_o, ram_wen_o);
    if (in_rdy_o !== 1'b0 || ram_wen_o !== 1'b1) errors++;
    checks++;
    if (blk_vld_o !== from_ready) begin
      errors++;
      $display("FAIL start_blk_vld: got %b want %b", blk_vld_o, from_ready);
    end
    next_cycle();
    start_i = 1'b0;
  endtask

  task automatic load_beats(input int n, input bit throttle, input bit alt,
                            output int done_cnt, output int writes);
    int beat;
    int k;
    bit v;
    logic [WW-1:0] d;
    beat = 0;
    k = 0;
    done_cnt = 0;
    while (beat < n && k < 4*BB) begin
      v = throttle ? (k % 2 == 0) : 1'b1;
      d = pat(beat, alt);
      in_val_i = v;
      in_dat_i = d;
      @(negedge clk);
      checks++;
      if (in_rdy_o !== 1'b1 || blk_vld_o !== 1'b0) begin
        errors++;
        $display("FAIL load_flags: in_rdy=%b blk_vld=%b, want 1/0", in_rdy_o, blk_vld_o);
      end
      if (v) begin
        checks++;
        if ({ram_cen_o, ram_wen_o} !== 2'b00 || ram_addr_o !== AW'(beat) || ram_dat_o !== d) begin
          errors++;
          $display("FAIL write_%0d: cen=%b wen=%b addr=%0d dat=%h, want 0/0 addr=%0d dat=%h",
                   beat, ram_cen_o, ram_wen_o, ram_addr_o, ram_dat_o, beat, d);
        end
        checks++;
        if (done_o !== 1'(beat == BB-1)) begin
          errors++;
          $display("FAIL done_at_%0d: got %b want %b", beat, done_o, (beat == BB-1));
        end
        beat++;
      end else begin
        checks++;
        if (ram_cen_o !== 1'b1 || done_o !== 1'b0) begin
          errors++;
          $display("FAIL stall_cycle: cen=%b done=%b, want 1/0", ram_cen_o, done_o);
        end
      end
      if (done_o === 1'b1) done_cnt++;
      next_cycle();
      k++;
    end
    in_val_i = 1'b0;
    writes = beat;
    checks++;
    if (beat < n) begin
      errors++;
      $display("FAIL load_timeout: beats=%0d want %0d", beat, n);
    end
  endtask

  task automatic read_burst();
    logic [WW-1:0] exp;
    int n;
    n = rd_addrs.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        rd_req_i  = 1'b1;
        rd_addr_i = AW'(rd_addrs[i]);
      end else begin
        rd_req_i = 1'b0;
      end
      @(negedge clk);
      if (i < n) begin
        checks++;
        if (ram_cen_o !== 1'b0 || ram_wen_o !== 1'b1 || ram_addr_o !== AW'(rd_addrs[i])) begin
          errors++;
          $display("FAIL rd_issue_%0d: cen=%b wen=%b addr=%0d, want 0/1 addr=%0d",
                   i, ram_cen_o, ram_wen_o, ram_addr_o, rd_addrs[i]);
        end
      end
      checks++;
      if (i == 0) begin
        if (rd_val_o !== 1'b0) begin
          errors++;
          $display("FAIL rd_val_early: got %b want 0", rd_val_o);
        end
      end else if (rd_val_o !== 1'b1 || rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_val_%0d: got %b want 1", i, rd_val_o);
      end else begin
        exp = rd_q.pop_front();
        checks++;
        if (rd_dat_o !== exp) begin
          errors++;
          $display("FAIL rd_dat_%0d: got %h want %h", i, rd_dat_o, exp);
        end
      end
      if (i < n) rd_q.push_back(pat(rd_addrs[i], 1'b0));
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (rd_val_o !== 1'b0) begin
      errors++;
      $display("FAIL rd_val_tail: got %b want 0", rd_val_o);
    end
    next_cycle();
    rd_addrs.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({in_rdy_o, done_o, blk_vld_o, rd_val_o} !== 4'b0000 || rd_dat_o !== '0) begin
        errors++;
        $display("FAIL reset_outputs: rdy=%b done=%b vld=%b rv=%b rd=%h, want all 0",
                 in_rdy_o, done_o, blk_vld_o, rd_val_o, rd_dat_o);
      end
      checks++;
      if ({ram_cen_o, ram_wen_o, ram_oen_o} !== 3'b110 || ram_addr_o !== '0 || ram_dat_o !== '0) begin
        errors++;
        $display("FAIL reset_ram_pins: cen=%b wen=%b oen=%b addr=%0d dat=%h, want 1/1/0 0 0",
                 ram_cen_o, ram_wen_o, ram_oen_o, ram_addr_o, ram_dat_o);
      end
      next_cycle();
    end
    rstn = 1'b1;
    rd_req_i = 1'b1;
    rd_addr_i = AW'(3);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rd_req_i = 1'b0;
      @(negedge clk);
      checks++;
      if (rd_val_o !== 1'b0 || ram_cen_o !== 1'b1) begin
        errors++;
        $display("FAIL idle_read_%0d: rd_val=%b cen=%b, want 0/1", i, rd_val_o, ram_cen_o);
      end
      next_cycle();
    end
  endtask

  task automatic test_full_load();
    int dc;
    int wr;
    pulse_start(1'b0);
    load_beats(BB, 1'b0, 1'b0, dc, wr);
    checks++;
    if (dc !== 1) begin
      errors++;
      $display("FAIL full_done_count: got %0d want 1", dc);
    end
    @(negedge clk);
    checks++;
    if (blk_vld_o !== 1'b1 || in_rdy_o !== 1'b0 || ram_cen_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL full_after: vld=%b rdy=%b cen=%b done=%b, want 1/0/1/0",
               blk_vld_o, in_rdy_o, ram_cen_o, done_o);
    end
    checks++;
    if (ram_addr_o !== AW'(BB-1) || ram_dat_o !== pat(BB-1, 1'b0)) begin
      errors++;
      $display("FAIL idle_hold: addr=%0d dat=%h, want %0d %h",
               ram_addr_o, ram_dat_o, BB-1, pat(BB-1, 1'b0));
    end
    next_cycle();
  endtask

  task automatic test_throttled_load();
    int dc;
    int wr;
    pulse_start(1'b1);
    load_beats(BB, 1'b1, 1'b0, dc, wr);
    checks++;
    if (dc !== 1 || wr !== BB) begin
      errors++;
      $display("FAIL throttle_counts: done=%0d writes=%0d, want 1 %0d", dc, wr, BB);
    end
    @(negedge clk);
    checks++;
    if (dut.wr_cnt !== 6'd32 || blk_vld_o !== 1'b1) begin
      errors++;
      $display("FAIL throttle_end: wr_cnt=%0d vld=%b, want 32/1", dut.wr_cnt, blk_vld_o);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    rd_addrs.push_back(31);
    rd_addrs.push_back(0);
    rd_addrs.push_back(17);
    read_burst();
  endtask

  task automatic test_start_with_read();
    logic [WW-1:0] exp;
    start_i = 1'b1;
    rd_req_i = 1'b1;
    rd_addr_i = AW'(5);
    @(negedge clk);
    checks++;
    if (ram_cen_o !== 1'b0 || ram_wen_o !== 1'b1 || ram_addr_o !== AW'(5) || in_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL start_rd_issue: cen=%b wen=%b addr=%0d rdy=%b, want 0/1 5 0",
               ram_cen_o, ram_wen_o, ram_addr_o, in_rdy_o);
    end
    rd_q.push_back(pat(5, 1'b0));
    next_cycle();
    start_i = 1'b0;
    rd_req_i = 1'b0;
    @(negedge clk);
    exp = rd_q.pop_front();
    checks++;
    if (rd_val_o !== 1'b1 || rd_dat_o !== exp) begin
      errors++;
      $display("FAIL start_rd_data: rv=%b dat=%h, want 1 %h", rd_val_o, rd_dat_o, exp);
    end
    checks++;
    if (in_rdy_o !== 1'b1 || blk_vld_o !== 1'b0 || ram_cen_o !== 1'b1) begin
      errors++;
      $display("FAIL start_rd_state: rdy=%b vld=%b cen=%b, want 1/0/1", in_rdy_o, blk_vld_o, ram_cen_o);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_load();
    int dc;
    int wr;
    int dtot;
    load_beats(10, 1'b0, 1'b1, dc, wr);
    dtot = dc;
    in_val_i = 1'b1;
    in_dat_i = pat(10, 1'b1);
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (in_rdy_o !== 1'b0 || ram_cen_o !== 1'b1 || done_o !== 1'b0 || blk_vld_o !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_%0d: rdy=%b cen=%b done=%b vld=%b, want 0/1/0/0",
                 i, in_rdy_o, ram_cen_o, done_o, blk_vld_o);
      end
      if (done_o === 1'b1) dtot++;
      next_cycle();
    end
    rstn = 1'b1;
    in_val_i = 1'b0;
    @(negedge clk);
    checks++;
    if (in_rdy_o !== 1'b0 || ram_cen_o !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: rdy=%b cen=%b, want 0/1", in_rdy_o, ram_cen_o);
    end
    next_cycle();
    checks++;
    if (dtot !== 0) begin
      errors++;
      $display("FAIL partial_done: got %0d pulses want 0", dtot);
    end
    pulse_start(1'b0);
    load_beats(BB, 1'b0, 1'b0, dc, wr);
    checks++;
    if (dc !== 1) begin
      errors++;
      $display("FAIL reload_done_count: got %0d want 1", dc);
    end
    next_cycle();
    rd_addrs.push_back(9);
    rd_addrs.push_back(40 % 32);
    read_burst();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_load();
    test_throttled_load();
    test_back_to_back();
    test_start_with_read();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
